// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game core.
package memory_game_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHOW   = 2'b01,
    ST_ANSWER = 2'b10,
    ST_RESULT = 2'b11
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/memory_game_lfsr.sv
// Free-running right-shift Galois LFSR; a non-zero SEED keeps it out of the all-zero lockup.
module memory_game_lfsr #(
  parameter int           W    = 8,
  parameter logic [W-1:0] SEED = 'hA5,
  parameter logic [W-1:0] TAPS = 'hB8
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] value
);
  always_ff @(posedge clk) begin
    if (reset)         value <= SEED;
    else if (value[0]) value <= (value >> 1) ^ TAPS;
    else               value <= value >> 1;
  end
endmodule

// File: rtl/memory_game.sv
// Memory game round controller: pick question, show it for load cycles, capture and grade answer.
module memory_game
  import memory_game_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic             submit,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] display,
  output logic [1:0]       result,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] temp,
  output logic [WIDTH-1:0] inp,
  output logic [1:0]       state
);
  state_t           st, st_d;
  logic [WIDTH-1:0] qn_d, temp_d, inp_d, lfsr_val;
  logic [1:0]       result_d;
  logic             submit_q, sub_pulse;

  memory_game_lfsr #(
    .W    (WIDTH),
    .SEED (SEED),
    .TAPS (WIDTH'(LFSR_TAPS))
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_val)
  );

  // A held button registers once; SHOW/IDLE simply ignore the pulse.
  assign sub_pulse = submit & ~submit_q;
  assign state     = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= ST_IDLE;
      qn       <= '0;
      temp     <= '0;
      inp      <= '0;
      result   <= RES_NONE;
      submit_q <= 1'b0;
    end else begin
      st       <= st_d;
      qn       <= qn_d;
      temp     <= temp_d;
      inp      <= inp_d;
      result   <= result_d;
      submit_q <= submit;
    end
  end

  always_comb begin
    st_d     = st;
    qn_d     = qn;
    temp_d   = temp;
    inp_d    = inp;
    result_d = result;
    unique case (st)
      ST_IDLE: begin
        qn_d     = lfsr_val;
        temp_d   = (load == '0) ? WIDTH'(1) : load;
        result_d = RES_NONE;
        st_d     = ST_SHOW;
      end
      ST_SHOW: begin
        // Exit on 1 so the countdown never wraps below zero.
        if (temp == WIDTH'(1)) begin
          temp_d = '0;
          st_d   = ST_ANSWER;
        end else begin
          temp_d = temp - WIDTH'(1);
        end
      end
      ST_ANSWER: begin
        if (sub_pulse) begin
          inp_d    = x;
          result_d = (x == qn) ? RES_WIN : RES_LOSE;
          st_d     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (sub_pulse) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    display = '0;
    case (st)
      ST_SHOW:   display = qn;
      ST_RESULT: display = inp;
      default:   display = '0;
    endcase
  end
endmodule

// File: tb/tb_memory_game.sv
// Randomized bench for memory_game against a round-level reference model.
module tb_memory_game;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x, load, display, qn, temp, inp;
  logic       submit;
  logic [1:0] result, state;

  int nvec = 0;
  int nerr = 0;

  // Reference model: phase 0 idle, 1 showing, 2 awaiting answer, 3 showing result.
  int   m_phase, m_qn, m_left, m_inp, m_res, m_lfsr;
  bit   m_subq;

  memory_game #(.WIDTH(8), .SEED(8'hA5)) dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .submit  (submit),
    .load    (load),
    .display (display),
    .result  (result),
    .qn      (qn),
    .temp    (temp),
    .inp     (inp),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int v);
    return (v % 2 == 1) ? ((v / 2) ^ 'hB8) : (v / 2);
  endfunction

  task automatic model_step(input bit r, input int xv, input bit s, input int ld);
    bit press;
    if (r) begin
      m_phase = 0; m_qn = 0; m_left = 0; m_inp = 0; m_res = 0;
      m_lfsr = 'hA5; m_subq = 0;
      return;
    end
    press = s && !m_subq;
    case (m_phase)
      0: begin
        m_qn = m_lfsr; m_left = (ld == 0) ? 1 : ld; m_res = 0; m_phase = 1;
      end
      1: begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 2;
      end
      2: if (press) begin
        m_inp = xv; m_res = (xv == m_qn) ? 1 : 2; m_phase = 3;
      end
      default: if (press) m_phase = 0;
    endcase
    m_lfsr = lfsr_next(m_lfsr);
    m_subq = s;
  endtask

  // Apply one cycle of inputs, advance model, compare every output on the falling edge.
  task automatic cyc(input bit r, input int xv, input bit s, input int ld);
    int exp_disp;
    reset = r; x = xv[7:0]; submit = s; load = ld[7:0];
    @(posedge clk);
    model_step(r, xv, s, ld);
    @(negedge clk);
    exp_disp = (m_phase == 1) ? m_qn : (m_phase == 3) ? m_inp : 0;
    chk("state",   int'(state),   m_phase);
    chk("qn",      int'(qn),      m_qn);
    chk("temp",    int'(temp),    m_left);
    chk("inp",     int'(inp),     m_inp);
    chk("result",  int'(result),  m_res);
    chk("display", int'(display), exp_disp);
  endtask

  initial begin
    int ld, xv;
    bit s;
    m_subq = 0;
    @(negedge clk);

    // First round: correct answer, load=3.
    cyc(1, 0, 0, 3);
    chk("rst_state", int'(state), 0);
    chk("rst_disp",  int'(display), 0);
    cyc(0, 0, 0, 3);
    chk("q1_qn", int'(qn), 'hA5);
    chk("q1_show", int'(display), 'hA5);
    cyc(0, 0, 0, 15);
    cyc(0, 0, 0, 15);
    chk("q1_still_show", int'(state), 1);
    cyc(0, 0, 0, 3);
    chk("q1_answer", int'(state), 2);
    chk("q1_blank", int'(display), 0);
    cyc(0, 'hA5, 1, 3);
    chk("q1_win", int'(result), 1);
    chk("q1_inp", int'(display), 'hA5);
    cyc(0, 'hA5, 0, 3);
    cyc(0, 0, 1, 3);
    chk("q1_to_idle", int'(state), 0);
    cyc(0, 0, 1, 0);
    chk("q2_newq", int'(qn != 8'hA5), 1);
    // Held submit through SHOW and into ANSWER must not capture.
    cyc(0, 0, 1, 0);
    chk("q2_answer", int'(state), 2);
    cyc(0, 'h43, 1, 0);
    chk("q2_held", int'(state), 2);
    cyc(0, 'h43, 0, 0);
    cyc(0, 'h43, 1, 0);
    chk("q2_lose", int'(result), 2);
    chk("q2_disp", int'(display), 'h43);
    cyc(0, 'h43, 1, 0);
    chk("q2_hold_result", int'(state), 3);
    // Reset while showing the result.
    cyc(1, 0, 0, 0);
    chk("mid_rst_state", int'(state), 0);
    cyc(0, 0, 0, 2);
    chk("mid_rst_seed", int'(qn), 'hA5);

    // Randomized play including occasional resets and the 255-cycle show.
    s = 0;
    for (int i = 0; i < 4000; i++) begin
      int pick;
      pick = $urandom_range(0, 99);
      ld = (pick < 70) ? $urandom_range(0, 4) : (pick < 97) ? $urandom_range(5, 20) : 255;
      if ($urandom_range(0, 3) == 0) s = !s;
      xv = ($urandom_range(0, 1) == 1) ? m_qn : $urandom_range(0, 255);
      cyc(($urandom_range(0, 149) == 0), xv, s, ld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
